multicycle_ctrl: RTL

//  Moore FSM that sequences the shared-memory multi-cycle MIPS datapath: fetch, decode, execute, memory access, writeback.

---
 rtl/mips_ctrl_pkg.sv | 58 +++++
 rtl/ctrl_wait_timer.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the MIPS control path: opcode/funct values, the
// multi-cycle FSM state encoding and the datapath mux/ALU select codes.
// Used by the single-cycle decoder, multicycle_ctrl and its testbench.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BMEM  = 6'h14;
    localparam logic [5:0] OP_JS    = 6'h13;

    // R-type funct codes with special sequencing (IR[5:0])
    localparam logic [5:0] FN_JMEM    = 6'h2D;
    localparam logic [5:0] FN_PCTOREG = 6'h16;

    // Multi-cycle FSM states; the encoding is visible on the debug port
    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ADDR   = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWR  = 4'd5,
        S_LDWB   = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_PCWB   = 4'd9,
        S_BEQ    = 4'd10,
        S_JLOAD  = 4'd11
    } state_t;

    // ALU B-operand select
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_S2 = 2'd3;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_MDR    = 2'd2;

    // States that hold a request on the shared memory port
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// -----------------------------------------------------------------------------
// ctrl_wait_timer
// Counts cycles spent waiting for mem_ready in a memory state and flags an
// abort when the count reaches TIMEOUT with the access still outstanding.
// TIMEOUT must be < 2**TIMEOUT_W.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   async, active-high
//   i_active   in   FSM is in a memory state (request on the port)
//   i_ready    in   memory completes the access this cycle
//   o_expired  out  abort the access this cycle (combinational)
// -----------------------------------------------------------------------------
module ctrl_wait_timer #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expired
);

    logic [TIMEOUT_W-1:0] r_count;
    logic                 w_at_limit;

    assign w_at_limit = (r_count == TIMEOUT_W'(TIMEOUT));
    assign o_expired  = i_active && w_at_limit && !i_ready;

    // Any cycle that ends an access (completion, abort, or no access at all)
    // returns the count to 0, so every entry into a memory state starts at 0,
    // including FETCH re-entered from a FETCH timeout.
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_active || i_ready || w_at_limit) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore FSM sequencing the shared-memory multi-cycle MIPS datapath through
// fetch, decode, execute, memory access and writeback. Decodes R-type
// (incl. funct jmem/pctoreg), lw, sw, beq, bmem and js.
// Optional feature macro: PERF_CNT_EN adds cyc_cnt / instr_cnt counters.
// Ports:
//   clk, reset            clock (rising), async active-high reset
//   opcode, funct         IR[31:26], IR[5:0]; valid from DECODE onward
//   eq                    register comparator rs==rt
//   mem_ready             memory completes the current access
//   iord                  memory address select (1 = ALUOut, 0 = PC)
//   mem_read, mem_write   memory requests, held until mem_ready/abort
//   ir_write, mdr_write   IR / MDR load strobes
//   reg_dst, mem_to_reg,
//   pc_to_reg, reg_write  register-file writeback controls
//   alu_src_a, alu_src_b,
//   alu_op                ALU operand/operation selects
//   pc_write, pc_source   PC load and source select
//   illegal               undecoded opcode seen in DECODE
//   mem_timeout           memory access aborted this cycle
//   state                 current FSM state (debug)
//   cyc_cnt, instr_cnt    performance counters (PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
`ifdef PERF_CNT_EN
    ,
    parameter int PERF_W    = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       eq,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state
`ifdef PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cyc_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    state_t r_state;

    // Instruction decode from the held IR fields
    logic w_rtype, w_lw, w_sw, w_beq, w_bmem, w_js;
    logic w_jmem, w_pctoreg, w_legal;
    logic w_expired;

    assign w_rtype    = (opcode == OP_RTYPE);
    assign w_lw       = (opcode == OP_LW);
    assign w_sw       = (opcode == OP_SW);
    assign w_beq      = (opcode == OP_BEQ);
    assign w_bmem     = (opcode == OP_BMEM);
    assign w_js       = (opcode == OP_JS);
    assign w_jmem     = w_rtype && (funct == FN_JMEM);
    assign w_pctoreg  = w_rtype && (funct == FN_PCTOREG);
    assign w_legal    = w_rtype || w_lw || w_sw || w_beq || w_bmem || w_js;

    ctrl_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_active  (is_mem_state(r_state)),
        .i_ready   (mem_ready),
        .o_expired (w_expired)
    );

    // State register and transitions. A memory state leaves only on
    // mem_ready or on abort; an abort always restarts at FETCH without
    // touching PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RST;
        end else begin
            case (r_state)
                S_RST:    r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)      r_state <= S_DECODE;
                    else if (w_expired) r_state <= S_FETCH;
                end
                S_DECODE: begin
                    if (w_jmem)                      r_state <= S_ADDR;
                    else if (w_pctoreg)              r_state <= S_PCWB;
                    else if (w_rtype)                r_state <= S_REXEC;
                    else if (w_lw || w_sw || w_bmem || w_js)
                                                     r_state <= S_ADDR;
                    else if (w_beq)                  r_state <= S_BEQ;
                    else                             r_state <= S_FETCH;
                end
                S_ADDR:   r_state <= w_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (mem_ready) begin
                        if (w_lw)        r_state <= S_LDWB;
                        else if (w_jmem) r_state <= S_JLOAD;
                        else if (w_bmem) r_state <= eq ? S_JLOAD : S_FETCH;
                        else if (w_js)   r_state <= S_MEMWR;
                        else             r_state <= S_FETCH;
                    end else if (w_expired) begin
                        r_state <= S_FETCH;
                    end
                end
                // js finishes with JLOAD: the old word latched in MEMRD
                // becomes the new PC after PC has been stored.
                S_MEMWR: begin
                    if (mem_ready)      r_state <= w_js ? S_JLOAD : S_FETCH;
                    else if (w_expired) r_state <= S_FETCH;
                end
                S_REXEC:  r_state <= S_RWB;
                default:  r_state <= S_FETCH;  // LDWB, RWB, PCWB, BEQ, JLOAD
            endcase
        end
    end

    // Datapath controls decoded from the state; the only input gating is
    // on strobes that must fire exactly once per access (mem_ready) and on
    // the branch-taken condition.
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_to_reg  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        pc_source  = PCSRC_ALU;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_S2;
                illegal   = !w_legal;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                // jmem has no immediate; its rt field is $zero so rs+rt = rs
                alu_src_b = w_jmem ? SRCB_RT : SRCB_IMM;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                mem_read  = 1'b1;
                mdr_write = mem_ready;
            end
            // Write-data select (rt, or PC for js) is taken from the opcode
            // by the datapath.
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_LDWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_REXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            // PC already holds PC+4 from FETCH
            S_PCWB: begin
                reg_dst   = 1'b1;
                pc_to_reg = 1'b1;
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = eq;
            end
            S_JLOAD: begin
                pc_source = PCSRC_MDR;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_timeout = w_expired;
    assign state       = r_state;

`ifdef PERF_CNT_EN
    // One instruction retires on every edge into FETCH, except the first
    // one out of RST and aborted accesses.
    logic w_retire;

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_LDWB, S_RWB, S_PCWB, S_BEQ, S_JLOAD: w_retire = 1'b1;
            S_DECODE: w_retire = !w_legal;
            S_MEMRD:  w_retire = mem_ready && !w_lw && !w_jmem && !w_js
                                 && !(w_bmem && eq);
            S_MEMWR:  w_retire = mem_ready && !w_js;
            default:  w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + PERF_W'(1);
            if (w_retire) instr_cnt <= instr_cnt + PERF_W'(1);
        end
    end
`endif

endmodule
